// File: rtl/mem_compare_checker_pkg.sv
// Shared types for the memory compare checker.
//   state_e : scan controller states
//   mode_e  : compare mode latched at start (full scan / stop on first mismatch)
package pkg_mem_check;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef enum logic {
    CMP_FULL       = 1'b0,
    CMP_STOP_FIRST = 1'b1
  } mode_e;

endpackage

// File: rtl/mem_compare_checker_sat_counter.sv
// Saturating up-counter with synchronous clear.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   clr_i         : clear to zero (wins over increment)
//   inc_i         : increment by one, sticks at all-ones
//   count_o       : current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] count_o
);

  logic [WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && (count_q != '1)) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/mem_compare_checker.sv
// Scans a window of two memories (DUT and gold) through a shared read port and
// counts words compared and masked mismatches.
//   sys_clk, sys_rst_n          : clock, asynchronous active-low reset
//   start, abort, mode          : scan request, cancel, compare mode
//   base_addr, length, cmp_mask : scan window and compared bits (latched at start)
//   rd_en, rd_addr              : shared read strobe/address
//   dut_rd_data, gold_rd_data   : read data, one cycle after rd_en
//   busy, done                  : scan in progress, completion pulse
//   word_count, err_count       : saturating result counters
//   first_err_valid/_addr       : address of the first mismatch
//
// state | meaning
// IDLE  | waiting for start; results hold
// SCAN  | issuing one read per cycle, comparing the previous one
// DRAIN | comparing the last issued read
// DONE  | one-cycle done pulse
module mem_compare_checker
  import pkg_mem_check::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 10,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  sys_clk,
  input  logic                  sys_rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic                  mode,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   length,
  input  logic [DATA_WIDTH-1:0] cmp_mask,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] dut_rd_data,
  input  logic [DATA_WIDTH-1:0] gold_rd_data,
  output logic                  busy,
  output logic                  done,
  output logic [CNT_WIDTH-1:0]  word_count,
  output logic [CNT_WIDTH-1:0]  err_count,
  output logic                  first_err_valid,
  output logic [ADDR_WIDTH-1:0] first_err_addr
);

  localparam logic [ADDR_WIDTH:0] REM_LAST = {{ADDR_WIDTH{1'b0}}, 1'b1};

  state_e                state_q, state_d;
  mode_e                 mode_q, mode_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic [ADDR_WIDTH:0]   rem_q, rem_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] hold_q, hold_d;
  logic                  cmp_valid_q, cmp_valid_d;
  logic [ADDR_WIDTH-1:0] cmp_addr_q, cmp_addr_d;
  logic                  fev_q, fev_d;
  logic [ADDR_WIDTH-1:0] fea_q, fea_d;

  logic mismatch, stop_hit, active, accept, word_inc, err_inc;

  assign mismatch = cmp_valid_q && (((dut_rd_data ^ gold_rd_data) & mask_q) != '0);
  assign stop_hit = mismatch && (mode_q == CMP_STOP_FIRST);
  assign active   = (state_q == SCAN) || (state_q == DRAIN);
  assign accept   = (state_q == IDLE) && start;
  assign word_inc = active && cmp_valid_q;
  assign err_inc  = active && mismatch;

  // A stop-on-first mismatch suppresses the read issued in the same cycle.
  assign rd_en   = (state_q == SCAN) && !stop_hit;
  // Outside read cycles the address shows the last address actually issued.
  assign rd_addr = rd_en ? addr_q : hold_q;
  assign busy    = (state_q != IDLE);
  assign done    = (state_q == DONE);

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    mask_d      = mask_q;
    rem_d       = rem_q;
    addr_d      = addr_q;
    hold_d      = hold_q;
    cmp_valid_d = 1'b0;
    cmp_addr_d  = cmp_addr_q;
    fev_d       = fev_q;
    fea_d       = fea_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          mode_d  = mode_e'(mode);
          mask_d  = cmp_mask;
          addr_d  = base_addr;
          rem_d   = length;
          fev_d   = 1'b0;
          fea_d   = '0;
          state_d = (length == '0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (rd_en) begin
          hold_d      = addr_q;
          addr_d      = addr_q + 1'b1;
          rem_d       = rem_q - 1'b1;
          // A read issued in the abort cycle is never compared.
          cmp_valid_d = !abort;
          cmp_addr_d  = addr_q;
        end
        if (abort) begin
          state_d = IDLE;
        end else if (stop_hit) begin
          state_d = DONE;
        end else if (rem_q == REM_LAST) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        state_d = abort ? IDLE : DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (err_inc && !fev_q) begin
      fev_d = 1'b1;
      fea_d = cmp_addr_q;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= IDLE;
      mode_q      <= CMP_FULL;
      mask_q      <= '0;
      rem_q       <= '0;
      addr_q      <= '0;
      hold_q      <= '0;
      cmp_valid_q <= 1'b0;
      cmp_addr_q  <= '0;
      fev_q       <= 1'b0;
      fea_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      rem_q       <= rem_d;
      addr_q      <= addr_d;
      hold_q      <= hold_d;
      cmp_valid_q <= cmp_valid_d;
      cmp_addr_q  <= cmp_addr_d;
      fev_q       <= fev_d;
      fea_q       <= fea_d;
    end
  end

  sat_counter #(.WIDTH(CNT_WIDTH)) u_word_cnt (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .clr_i   (accept),
    .inc_i   (word_inc),
    .count_o (word_count)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
    .clk_i   (sys_clk),
    .rst_ni  (sys_rst_n),
    .clr_i   (accept),
    .inc_i   (err_inc),
    .count_o (err_count)
  );

  assign first_err_valid = fev_q;
  assign first_err_addr  = fea_q;

endmodule

// File: tb/tb_mem_compare_checker.sv
module tb_mem_compare_checker;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 16;

  logic sys_clk = 1'b0;
  logic sys_rst_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // main instance
  logic          start = 1'b0, abort = 1'b0, mode = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [AW:0]   length = '0;
  logic [DW-1:0] cmp_mask = '1;
  logic          rd_en, busy, done, first_err_valid;
  logic [AW-1:0] rd_addr, first_err_addr;
  logic [DW-1:0] dut_rd_data = '0, gold_rd_data = '0;
  logic [CW-1:0] word_count, err_count;

  mem_compare_checker #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CNT_WIDTH(CW)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(start), .abort(abort), .mode(mode),
    .base_addr(base_addr), .length(length), .cmp_mask(cmp_mask), .rd_en(rd_en), .rd_addr(rd_addr),
    .dut_rd_data(dut_rd_data), .gold_rd_data(gold_rd_data), .busy(busy), .done(done),
    .word_count(word_count), .err_count(err_count), .first_err_valid(first_err_valid),
    .first_err_addr(first_err_addr)
  );

  // small instance: 4-bit addresses, 3-bit counters
  logic       s_start = 1'b0, s_abort = 1'b0, s_mode = 1'b0;
  logic [3:0] s_base = '0;
  logic [4:0] s_len = '0;
  logic [7:0] s_mask = 8'hFF, s_flip = 8'h00;
  logic       s_rd_en, s_busy, s_done, s_fev;
  logic [3:0] s_rd_addr, s_fea;
  logic [7:0] s_dut_d = '0, s_gold_d = '0;
  logic [2:0] s_wc, s_ec;

  mem_compare_checker #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .CNT_WIDTH(3)) dut_s (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .start(s_start), .abort(s_abort), .mode(s_mode),
    .base_addr(s_base), .length(s_len), .cmp_mask(s_mask), .rd_en(s_rd_en), .rd_addr(s_rd_addr),
    .dut_rd_data(s_dut_d), .gold_rd_data(s_gold_d), .busy(s_busy), .done(s_done),
    .word_count(s_wc), .err_count(s_ec), .first_err_valid(s_fev), .first_err_addr(s_fea)
  );

  // memories with one-cycle read latency
  logic [DW-1:0] dut_mem [1024];
  logic [DW-1:0] gold_mem [1024];

  always @(posedge sys_clk) begin
    if (rd_en) begin
      dut_rd_data  <= dut_mem[rd_addr];
      gold_rd_data <= gold_mem[rd_addr];
    end
    if (s_rd_en) begin
      s_dut_d  <= {4'h0, s_rd_addr};
      s_gold_d <= {4'h0, s_rd_addr} ^ s_flip;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // per-cycle expectations produced by the model, checked on the falling edge
  logic          exp_on = 1'b0;
  logic          exp_rd_en, exp_busy, exp_done, exp_fev;
  logic [AW-1:0] exp_addr, exp_fea;
  logic [CW-1:0] exp_wc, exp_ec;

  always @(negedge sys_clk) begin
    if (exp_on) begin
      chk("rd_en", 32'(rd_en), 32'(exp_rd_en));
      chk("rd_addr", 32'(rd_addr), 32'(exp_addr));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("word_count", 32'(word_count), 32'(exp_wc));
      chk("err_count", 32'(err_count), 32'(exp_ec));
      chk("first_err_valid", 32'(first_err_valid), 32'(exp_fev));
      if (exp_fev) chk("first_err_addr", 32'(first_err_addr), 32'(exp_fea));
    end
  end

  bit            mm [1024];
  int            m_W, m_err, m_D, m_fev;
  logic [AW-1:0] m_fea;
  logic [AW-1:0] prev_last = '0;

  // Model of one scan. a: 0 = no abort, >0 = abort in that cycle, <0 = random abort.
  // Cycle 0 is the start cycle; reads of word i happen in cycle i+1, compared in i+2.
  task automatic run_scan(input int b, input int len, input bit md,
                          input logic [DW-1:0] msk, input int a_in);
    int kstop, N, W, D, a, lastc, t_end, raw, cnt, fi, issued, total;
    logic [AW-1:0] ad;
    kstop = -1;
    for (int i = 0; i < len; i++) begin
      ad = AW'(b + i);
      mm[i] = (((dut_mem[ad] ^ gold_mem[ad]) & msk) != 0);
      if (md && mm[i] && kstop < 0) kstop = i;
    end
    N = (kstop >= 0) ? kstop + 1 : len;
    W = N;
    D = (len == 0) ? 1 : W + 2;
    a = a_in;
    if (a < 0) a = (len == 0) ? 0 : $urandom_range(1, D - 1);
    lastc = (a > 0) ? a : (1 << 30);
    t_end = ((a > 0) ? a + 1 : D) + 3;
    raw = 0; cnt = 0; fi = -1;

    start = 1'b1; mode = md; base_addr = AW'(b); length = (AW+1)'(len); cmp_mask = msk;
    @(posedge sys_clk); #1;
    start = 1'b0;
    for (int t = 1; t <= t_end; t++) begin
      abort = (t == a);
      raw = ((t - 1 < lastc) ? t - 1 : lastc) - 1;
      if (raw < 0) raw = 0;
      if (raw > W) raw = W;
      cnt = 0; fi = -1;
      for (int i = 0; i < raw; i++) begin
        if (mm[i]) begin
          cnt++;
          if (fi < 0) fi = i;
        end
      end
      issued = t - 1;
      if (issued > N) issued = N;
      if (issued > lastc) issued = lastc;
      exp_rd_en = (t <= N) && (t <= lastc);
      if (exp_rd_en) exp_addr = AW'(b + t - 1);
      else if (issued > 0) exp_addr = AW'(b + issued - 1);
      else exp_addr = prev_last;
      exp_busy = (a > 0) ? (t <= a) : (t <= D);
      exp_done = (a == 0) && (t == D);
      exp_wc   = CW'(raw);
      exp_ec   = CW'(cnt);
      exp_fev  = (fi >= 0);
      exp_fea  = (fi >= 0) ? AW'(b + fi) : '0;
      exp_on   = 1'b1;
      // a start during a running scan must be ignored, including its new parameters
      if (t == 2 && exp_busy && !exp_done) begin
        start = 1'b1; base_addr = ~AW'(b); mode = ~md;
      end else begin
        start = 1'b0;
      end
      @(posedge sys_clk); #1;
    end
    exp_on = 1'b0; abort = 1'b0; start = 1'b0;
    total = (N < lastc) ? N : lastc;
    if (total > 0) prev_last = AW'(b + total - 1);
    m_W = raw; m_err = cnt; m_fev = (fi >= 0) ? 1 : 0; m_fea = exp_fea; m_D = D;
  endtask

  logic [3:0] s_log [16];
  int         s_done_t;

  task automatic s_run(input int b, input int len);
    s_done_t = 0;
    s_start = 1'b1; s_base = 4'(b); s_len = 5'(len);
    @(posedge sys_clk); #1;
    s_start = 1'b0;
    for (int t = 1; t <= len + 3; t++) begin
      if (t <= len) begin
        chk("s_rd_en", 32'(s_rd_en), 32'(1));
        s_log[t-1] = s_rd_addr;
      end
      if (s_done) s_done_t = t;
      @(posedge sys_clk); #1;
    end
  endtask

  task automatic restore_gold();
    for (int i = 0; i < 1024; i++) gold_mem[i] = dut_mem[i];
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_fev"}, 32'(first_err_valid), 32'(0));
    chk({tag, "_rd_addr"}, 32'(rd_addr), 32'(0));
    chk({tag, "_wc"}, 32'(word_count), 32'(0));
    chk({tag, "_ec"}, 32'(err_count), 32'(0));
    chk({tag, "_fea"}, 32'(first_err_addr), 32'(0));
  endtask

  initial begin
    int b, len, md, a;
    logic [DW-1:0] msk;
    for (int i = 0; i < 1024; i++) dut_mem[i] = $urandom;
    restore_gold();
    repeat (3) @(posedge sys_clk);
    #1;
    chk_reset_outputs("reset");
    sys_rst_n = 1'b1;

    // identical memories, full address space
    run_scan(0, 1024, 1'b0, '1, 0);
    chk("m_full_D", 32'(m_D), 32'(1026));
    chk("m_full_W", 32'(m_W), 32'(1024));
    chk("full_wc", 32'(word_count), 32'(1024));
    chk("full_ec", 32'(err_count), 32'(0));
    chk("full_fev", 32'(first_err_valid), 32'(0));

    // single differing word
    gold_mem[5] = gold_mem[5] ^ 32'h0000_0100;
    run_scan(0, 16, 1'b0, '1, 0);
    chk("m_w5_err", 32'(m_err), 32'(1));
    chk("m_w5_fea", 32'(m_fea), 32'(5));
    chk("w5_ec", 32'(err_count), 32'(1));
    chk("w5_fea", 32'(first_err_addr), 32'(5));
    chk("w5_wc", 32'(word_count), 32'(16));
    restore_gold();

    // stop on first of two mismatches
    gold_mem[3] = gold_mem[3] ^ 32'h1;
    gold_mem[9] = gold_mem[9] ^ 32'h2;
    run_scan(0, 16, 1'b1, '1, 0);
    chk("m_stop_W", 32'(m_W), 32'(4));
    chk("m_stop_D", 32'(m_D), 32'(6));
    chk("stop_wc", 32'(word_count), 32'(4));
    chk("stop_ec", 32'(err_count), 32'(1));
    chk("stop_fea", 32'(first_err_addr), 32'(3));
    restore_gold();

    // masked-out bit 31, then the same difference unmasked
    gold_mem[2] = gold_mem[2] ^ 32'h8000_0000;
    run_scan(0, 8, 1'b0, 32'h7FFF_FFFF, 0);
    chk("m_mask_err", 32'(m_err), 32'(0));
    chk("mask_ec", 32'(err_count), 32'(0));
    run_scan(0, 8, 1'b0, '1, 0);
    chk("nomask_ec", 32'(err_count), 32'(1));
    restore_gold();

    // abort three cycles in
    run_scan(0, 10, 1'b0, '1, 3);
    chk("m_abort_W", 32'(m_W), 32'(2));
    chk("abort_wc", 32'(word_count), 32'(2));
    chk("abort_busy", 32'(busy), 32'(0));

    // zero length
    run_scan(100, 0, 1'b0, '1, 0);
    chk("m_len0_D", 32'(m_D), 32'(1));
    chk("len0_wc", 32'(word_count), 32'(0));

    // address wrap at the top of the space
    run_scan(1022, 4, 1'b0, '1, 0);

    // randomized scans
    for (int n = 0; n < 40; n++) begin
      restore_gold();
      b = $urandom_range(0, 1023);
      len = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 64);
      md = $urandom_range(0, 1);
      msk = ($urandom_range(0, 1) == 0) ? '1 : DW'($urandom);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 7) == 0)
          gold_mem[AW'(b + i)] = gold_mem[AW'(b + i)] ^ (32'h1 << $urandom_range(0, 31));
      end
      a = ($urandom_range(0, 3) == 0) ? -1 : 0;
      run_scan(b, len, md[0], msk, a);
    end
    restore_gold();

    // small instance: wrap with 4-bit addresses
    s_flip = 8'h00;
    s_run(14, 4);
    chk("s_addr0", 32'(s_log[0]), 32'(14));
    chk("s_addr1", 32'(s_log[1]), 32'(15));
    chk("s_addr2", 32'(s_log[2]), 32'(0));
    chk("s_addr3", 32'(s_log[3]), 32'(1));
    chk("s_wrap_done_t", 32'(s_done_t), 32'(6));
    chk("s_wrap_wc", 32'(s_wc), 32'(4));
    chk("s_wrap_ec", 32'(s_ec), 32'(0));

    // small instance: counters saturate at 7
    s_flip = 8'hFF;
    s_run(0, 12);
    chk("s_sat_wc", 32'(s_wc), 32'(7));
    chk("s_sat_ec", 32'(s_ec), 32'(7));
    chk("s_sat_fev", 32'(s_fev), 32'(1));
    chk("s_sat_fea", 32'(s_fea), 32'(0));
    chk("s_sat_done_t", 32'(s_done_t), 32'(14));
    s_flip = 8'h00;

    // reset in the middle of a scan, asserted between clock edges
    start = 1'b1; mode = 1'b0; base_addr = 10'd40; length = 11'd40; cmp_mask = '1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    repeat (5) @(posedge sys_clk);
    #2;
    chk("pre_rst_busy", 32'(busy), 32'(1));
    sys_rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge sys_clk); #1;
    chk_reset_outputs("inrst");
    sys_rst_n = 1'b1;
    prev_last = '0;
    // start presented with the release: accepted on the first edge
    run_scan(7, 5, 1'b0, '1, 0);
    chk("post_rst_wc", 32'(word_count), 32'(5));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
